// File: rtl/program_loader.sv
// Frames a valid/ready byte stream into 9-bit words, writes them to instruction
// memory from address 0, then starts the core. Optional: `define CHECKSUM_EN.
module program_loader #(
  parameter int D = 10,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_req,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         core_start,
  input  logic         core_done,
  output logic         busy,
  output logic         finished,
  output logic         err,
  output logic [D-1:0] word_count,
  output logic [3:0]   dbgState
);

  // Handshake: a byte moves when in_valid && in_ready at a rising clk edge;
  // in_ready depends on state only, never on in_valid.
  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_WORD_LO,
    S_WORD_HI,
`ifdef CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t       state;
  state_t       next;
  logic         accept;
  logic         startLoad;
  logic         lastWord;
  logic         lenBad;
  logic [7:0]   lenLo;
  logic [7:0]   wordLo;
  logic [15:0]  len;
  logic [D-1:0] addr;
`ifdef CHECKSUM_EN
  logic [7:0]   xorAcc;
`endif

  assign accept   = in_valid && in_ready;
  assign len      = {in_data, lenLo};
  // Rejecting any bit at or above D keeps the address counter from wrapping.
  assign lenBad   = (len == 16'd0) || (|len[15:D]);
  assign lastWord = (addr == word_count - D'(1));
  assign dbgState = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
    err       = 1'b0;
    startLoad = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_req) begin
          startLoad = 1'b1;
          next      = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next = lenBad ? S_ERR : S_WORD_LO;
      end
      S_WORD_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next = S_WORD_HI;
      end
      S_WORD_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
`ifdef CHECKSUM_EN
        if (in_valid) next = lastWord ? S_CHK : S_WORD_LO;
`else
        if (in_valid) next = lastWord ? S_RUN : S_WORD_LO;
`endif
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next = (in_data == xorAcc) ? S_RUN : S_ERR;
      end
`endif
      S_RUN: begin
        busy = 1'b1;
        if (core_done) next = S_DONE;
      end
      S_DONE: begin
        finished = 1'b1;
        if (load_req) begin
          startLoad = 1'b1;
          next      = S_LEN_LO;
        end
      end
      S_ERR: begin
        err = 1'b1;
        if (load_req) begin
          startLoad = 1'b1;
          next      = S_LEN_LO;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lenLo      <= '0;
      wordLo     <= '0;
      addr       <= '0;
      word_count <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_start <= 1'b0;
`ifdef CHECKSUM_EN
      xorAcc     <= '0;
`endif
    end else begin
      wr_en      <= 1'b0;
      core_start <= (next == S_RUN) && (state != S_RUN);
      if (startLoad) begin
        addr   <= '0;
`ifdef CHECKSUM_EN
        xorAcc <= '0;
`endif
      end
      if (accept) begin
        case (state)
          S_LEN_LO: lenLo <= in_data;
          S_LEN_HI: if (!lenBad) word_count <= len[D-1:0];
          S_WORD_LO: begin
            wordLo <= in_data;
`ifdef CHECKSUM_EN
            xorAcc <= xorAcc ^ in_data;
`endif
          end
          S_WORD_HI: begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= W'({in_data[0], wordLo});
            addr    <= addr + D'(1);
`ifdef CHECKSUM_EN
            xorAcc  <= xorAcc ^ in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: cycle table for the basic frames plus hand
// sequences for gapped streams, mid-load reset and (with CHECKSUM_EN) checksum.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       load_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;
  logic       core_start;
  logic       core_done;
  logic       busy;
  logic       finished;
  logic       err;
  logic [9:0] word_count;
  logic [3:0] dbgState;

  program_loader #(.D(10), .W(9)) dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_start(core_start), .core_done(core_done),
    .busy(busy), .finished(finished), .err(err),
    .word_count(word_count), .dbgState(dbgState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       cd;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       we;
    logic [9:0] wa;
    logic [8:0] wd;
    logic       cs;
    logic       bsy;
    logic       fin;
    logic       er;
    logic [9:0] wc;
  } vec_t;

  vec_t        vecs[$];
  logic [18:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          csCount = 0;
  bit          monEn = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic cd, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [9:0] wa, input logic [8:0] wd,
                     input logic cs, input logic bsy, input logic fin, input logic er,
                     input logic [9:0] wc);
    vec_t r;
    r.ld = ld; r.cd = cd; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.wa = wa;
    r.wd = wd; r.cs = cs; r.bsy = bsy; r.fin = fin; r.er = er; r.wc = wc;
    vecs.push_back(r);
  endtask

  // Scoreboard: every write strobe must match the head of exp_q.
  always @(negedge clk) begin
    logic [18:0] e;
    if (core_start) csCount++;
    if (monEn && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write addr=%0h data=%0h required=none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL sb_write actual=%0h/%0h required=%0h/%0h", wr_addr, wr_data, e[18:9], e[8:0]);
        end
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int n;
    bit ok;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        load_req = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
      end
      load_req = 1'b0;
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout byte=%0h actual=not_accepted required=accepted", b);
    end
  endtask

  task automatic pulseLoad();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic runCore(input string nm);
    int c0;
    bit seen;
    c0 = csCount;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk);
      seen = (csCount != c0);
    end
    #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_core_start_timeout actual=0 required=1", nm);
    end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    @(negedge clk);
    check({nm, "_finished"}, 32'(finished), 32'd1);
    check({nm, "_err"}, 32'(err), 32'd0);
    check({nm, "_core_start_count"}, 32'(csCount - c0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic sendFrame1(input bit gaps);
    logic [7:0] bytes [0:7];
    bytes = '{8'h03, 8'h00, 8'h12, 8'h01, 8'h34, 8'h00, 8'hFF, 8'h01};
    for (int i = 0; i < 8; i++) sendByte(bytes[i], gaps);
`ifdef CHECKSUM_EN
    sendByte(8'hD9, gaps);
`endif
  endtask

  initial begin
    reset = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00; core_done = 1'b0;

    // Test 1: frame 03 00 12 01 34 00 FF 01
    add(1,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,0,0, 10'd0);
    add(0,0,1,8'h03, 1,0,10'd0,9'h000,0, 1,0,0, 10'd0);
    add(0,0,1,8'h00, 1,0,10'd0,9'h000,0, 1,0,0, 10'd0);
    add(0,0,1,8'h12, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'h01, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'h34, 1,1,10'd0,9'h112,0, 1,0,0, 10'd3);
    add(0,0,1,8'h00, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'hFF, 1,1,10'd1,9'h034,0, 1,0,0, 10'd3);
    add(0,0,1,8'h01, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
`ifdef CHECKSUM_EN
    add(0,0,1,8'hD9, 1,1,10'd2,9'h1FF,0, 1,0,0, 10'd3);
    add(0,0,0,8'h00, 0,0,10'd0,9'h000,1, 1,0,0, 10'd3);
`else
    add(0,0,0,8'h00, 0,1,10'd2,9'h1FF,1, 1,0,0, 10'd3);
`endif
    add(0,1,0,8'h00, 0,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,1,0, 10'd3);
    // Test 2: zero length; offered byte in ERR must be ignored
    add(1,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,1,0, 10'd3);
    add(0,0,1,8'h00, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'h00, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'h12, 0,0,10'd0,9'h000,0, 0,0,1, 10'd3);
    add(0,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,0,1, 10'd3);
    // Test 3: len=1024 overflows D=10, then recover with a one-word frame
    add(1,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,0,1, 10'd3);
    add(0,0,1,8'h00, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'h04, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,0,1, 10'd3);
    add(1,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,0,1, 10'd3);
    add(0,0,1,8'h01, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'h00, 1,0,10'd0,9'h000,0, 1,0,0, 10'd3);
    add(0,0,1,8'hAB, 1,0,10'd0,9'h000,0, 1,0,0, 10'd1);
    add(0,0,1,8'h01, 1,0,10'd0,9'h000,0, 1,0,0, 10'd1);
`ifdef CHECKSUM_EN
    add(0,0,1,8'hAA, 1,1,10'd0,9'h1AB,0, 1,0,0, 10'd1);
    add(0,1,0,8'h00, 0,0,10'd0,9'h000,1, 1,0,0, 10'd1);
`else
    add(0,1,0,8'h00, 0,1,10'd0,9'h1AB,1, 1,0,0, 10'd1);
`endif
    add(0,0,0,8'h00, 0,0,10'd0,9'h000,0, 0,1,0, 10'd1);

    // Reset state, checked while reset is still asserted
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_state", 32'(dbgState), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      load_req  = vecs[i].ld;
      core_done = vecs[i].cd;
      in_valid  = vecs[i].v;
      in_data   = vecs[i].d;
      @(negedge clk);
      check($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
      check($sformatf("row%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].we));
      if (vecs[i].we) begin
        check($sformatf("row%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].wa));
        check($sformatf("row%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].wd));
      end
      check($sformatf("row%0d_core_start", i), 32'(core_start), 32'(vecs[i].cs));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
      check($sformatf("row%0d_finished", i), 32'(finished), 32'(vecs[i].fin));
      check($sformatf("row%0d_err", i), 32'(err), 32'(vecs[i].er));
      check($sformatf("row%0d_word_count", i), 32'(word_count), 32'(vecs[i].wc));
      @(posedge clk); #1;
    end
    load_req = 1'b0; core_done = 1'b0; in_valid = 1'b0;

    // Test 4: gapped stream with stray load_req pulses mid-frame
    monEn = 1;
    exp_q.push_back({10'd0, 9'h112});
    exp_q.push_back({10'd1, 9'h034});
    exp_q.push_back({10'd2, 9'h1FF});
    pulseLoad();
    sendFrame1(1);
    runCore("gap");
    check("gap_word_count", 32'(word_count), 32'd3);
    check("gap_writes_left", 32'(exp_q.size()), 32'd0);

    // Test 5: asynchronous reset after the first word
    exp_q.push_back({10'd0, 9'h112});
    pulseLoad();
    sendByte(8'h03, 0);
    sendByte(8'h00, 0);
    sendByte(8'h12, 0);
    sendByte(8'h01, 0);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_core_start", 32'(core_start), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_finished", 32'(finished), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_word_count", 32'(word_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("arst_writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.push_back({10'd0, 9'h112});
    exp_q.push_back({10'd1, 9'h034});
    exp_q.push_back({10'd2, 9'h1FF});
    pulseLoad();
    sendFrame1(0);
    runCore("rerun");
    check("rerun_writes_left", 32'(exp_q.size()), 32'd0);

`ifdef CHECKSUM_EN
    // Test 6: checksum match then mismatch
    begin
      int c0;
      exp_q.push_back({10'd0, 9'h112});
      pulseLoad();
      sendByte(8'h01, 0); sendByte(8'h00, 0); sendByte(8'h12, 0);
      sendByte(8'h01, 0); sendByte(8'h13, 0);
      runCore("chk_ok");
      exp_q.push_back({10'd0, 9'h112});
      c0 = csCount;
      pulseLoad();
      sendByte(8'h01, 0); sendByte(8'h00, 0); sendByte(8'h12, 0);
      sendByte(8'h01, 0); sendByte(8'h00, 0);
      repeat (3) @(posedge clk);
      #1;
      check("chk_bad_err", 32'(err), 32'd1);
      check("chk_bad_core_start", 32'(csCount - c0), 32'd0);
      check("chk_bad_writes_left", 32'(exp_q.size()), 32'd0);
    end
`endif

    monEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
